// File: rtl/dual_phase_sequencer.sv
// Start/done sequencer driving two overlapping phase enables a/b from per-run latched lengths/offset.
// Outputs are Moore-decoded from state/cnt; SEQ_OVERRUN_EN adds a sticky overrun flag for rises during a run.
module dual_phase_sequencer #(
  parameter int CW       = 4,
  parameter bit RST_IDLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic [CW-1:0] a_len,
  input  logic [CW-1:0] b_ofs,
  input  logic [CW-1:0] b_len,
  output logic          a,
  output logic          b,
  output logic          busy,
  output logic          done,
  output logic          overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CW:0] CNT_ONE = {{CW{1'b0}}, 1'b1};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW:0]   r_cnt;
  logic [CW:0]   w_cnt_nxt;
  logic [CW-1:0] r_a_len;
  logic [CW-1:0] r_b_ofs;
  logic [CW-1:0] r_b_len;
  logic          r_start_q;

  logic          w_rst;
  logic          w_rise;
  logic          w_accept;
  logic [CW:0]   w_b_end_in;
  logic [CW:0]   w_t_in;
  logic [CW:0]   w_b_end;
  logic [CW:0]   w_t_run;

  assign w_rst  = rst & RST_IDLE;
  assign w_rise = start & ~r_start_q;

  // Run length is one bit wider than the config so b_ofs+b_len never wraps.
  assign w_b_end_in = {1'b0, b_ofs} + {1'b0, b_len};
  assign w_t_in     = ({1'b0, a_len} > w_b_end_in) ? {1'b0, a_len} : w_b_end_in;
  assign w_b_end    = {1'b0, r_b_ofs} + {1'b0, r_b_len};
  assign w_t_run    = ({1'b0, r_a_len} > w_b_end) ? {1'b0, r_a_len} : w_b_end;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_accept = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == (w_t_run - CNT_ONE)) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_DONE: begin
        if (abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_rise) begin
          w_accept = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
        w_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
    // A zero-length run has nothing to enable, so it completes immediately.
    if (w_accept) begin
      w_cnt_nxt   = '0;
      w_state_nxt = (w_t_in == '0) ? S_DONE : S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_start_q <= 1'b0;
      r_a_len   <= '0;
      r_b_ofs   <= '0;
      r_b_len   <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_start_q <= start;
      if (w_accept) begin
        r_a_len <= a_len;
        r_b_ofs <= b_ofs;
        r_b_len <= b_len;
      end
    end
  end

  assign a    = (r_state == S_RUN) && (r_cnt < {1'b0, r_a_len});
  assign b    = (r_state == S_RUN) && (r_cnt >= {1'b0, r_b_ofs}) && (r_cnt < w_b_end);
  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);

`ifdef SEQ_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_overrun <= 1'b0;
    end else if ((r_state == S_RUN) && w_rise) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`else
  assign overrun = 1'b0;
`endif

endmodule
